hub75_bcm_seq: RTL
==================

// Module: hub75_bcm_seq
//
// PURPOSE
//  Per-row BCM plane sequencer; initiator side of the blanking controller's plane/go/rdy handshake.
//  For each row it requests the shifter to load one bit-plane and waits for the previous plane's display time to expire.
//  It then pulses the panel latch, updating the row address on a row's first plane, and starts the new plane's display time.
//  Sits between the frame/row controller (upstream) and the shifter + blanking blocks (downstream).
//
// PARAMETERS
//  N_PLANES    8  bit-planes per row; planes sent MSB first (index N_PLANES-1 down to 0)
//  LOG_N_ROWS  5  width of the panel row address
//  LATCH_LEN   2  cycles hub75_le held high per latch (legal 1..15)
//
// PORTS
//  clk           in   1           system clock
//  rst_n         in   1           async active-low reset
//  row_addr      in   LOG_N_ROWS  row to display; sampled when row_go & row_rdy
//  row_go        in   1           start sequencing a row
//  row_rdy       out  1           sequencer idle, may accept row_go
//  shift_plane   out  N_PLANES    one-hot plane to shift; valid while shift_go
//  shift_go      out  1           1-cycle shift request
//  shift_rdy     in   1           shifter idle/done
//  blank_plane   out  N_PLANES    one-hot plane length; valid while blank_go
//  blank_go      out  1           1-cycle display-time start
//  blank_rdy     in   1           blanking idle (previous plane expired)
//  hub75_addr    out  LOG_N_ROWS  panel row address
//  hub75_le      out  1           panel latch enable
//
// BEHAVIOUR
//  - All outputs registered. Reset (async, rst_n=0): state IDLE, plane idx=N_PLANES-1, row_rdy=1.
//    Reset also forces shift_go=0, blank_go=0, hub75_le=0, hub75_addr=0, shift_plane=0, blank_plane=0.
//  - Downstream contract: shift_rdy/blank_rdy go low the cycle after the matching go; seq never samples rdy in that cycle.
//  - FSM:
//    IDLE: row_rdy=1. row_go -> capture row_addr, first=1, p=N_PLANES-1, row_rdy<=0, ->SHIFT.
//    SHIFT: if shift_rdy: shift_go=1, shift_plane=1<<p for 1 cycle, ->SHIFT_HOLD; else wait.
//    SHIFT_HOLD: 1 cycle, ignore shift_rdy, ->SHIFT_WAIT.
//    SHIFT_WAIT: wait shift_rdy=1, then ->BLANK_WAIT.
//    BLANK_WAIT: wait blank_rdy=1 (panel now blanked); ->LATCH; if first, hub75_addr<=captured row same edge.
//    LATCH: hub75_le=1 exactly LATCH_LEN cycles (4-bit counter), ->DISPLAY.
//    DISPLAY: blank_go=1, blank_plane=1<<p for 1 cycle; first<=0.
//      If p==0 ->IDLE (row_rdy=1 next cycle), else p<=p-1, ->SHIFT.
//  - Overlap: shifting plane p-1 proceeds while plane p displays; next row's first shift overlaps last plane display.
//  - hub75_addr changes only in the BLANK_WAIT->LATCH edge with blank_rdy=1, never while displaying.
//  - shift_rdy and blank_rdy both high on SHIFT_WAIT exit: BLANK_WAIT->LATCH next cycle (one cycle per state).
//  - row_go while row_rdy=0: ignored, no capture. row_go held high: new row accepted on each IDLE entry.
//  - N_PLANES=1: single pass, p stays 0. Plane index width = max(1,clog2(N_PLANES)).
//  - Reset mid-sequence: immediate return to reset values; no partial latch/go pulse completes.
//
// TESTING
//  (N_PLANES=4, LOG_N_ROWS=5, LATCH_LEN=2, shifter/blanking models with rdy contract)
//  1 reset: rst_n=0 mid-LATCH -> hub75_le=0, blank_go=0, hub75_addr=0, row_rdy=1 same cycle.
//  2 row_addr=5, row_go 1 cycle, instant rdy -> shift_plane 8,4,2,1 then blank_plane 8,4,2,1 in order.
//    Each shift_plane precedes its blank_plane; 4 latches of 2 cycles each; addr=5 first at latch 1.
//  3 blank_rdy held low 100 cycles after shift done -> hub75_le stays 0; latch starts 1 cycle after blank_rdy rises.
//  4 row 5 then row 6 back-to-back -> addr 5->6 only while blank_rdy=1 before row-6 plane-8 latch.
//    Row-6 shift_go issued while row-5 plane 1 displays.
//  5 row_go pulsed during row sequence -> ignored; exactly 4 blank_go pulses, addr unchanged.
//  6 shift_rdy slow (50 cycles) -> no blank_go before shift completes; blank_go count == shift_go count.

Source files
------------

// File: rtl/hub75_bcm_seq.sv
// hub75_bcm_seq
//   Per-row bit-plane sequencer for a HUB75 panel using binary coded modulation.
//   For each accepted row it walks the bit-planes MSB first. For each plane it:
//     - asks the shifter to load the plane,
//     - waits for the previous plane's display time to run out,
//     - pulses the panel latch (updating the row address on the row's first plane),
//     - starts the new plane's display time in the blanking block.
//   Shifting the next plane overlaps with the current plane's display time.
//
// Ports
//   clk, rst_n               system clock, async active-low reset
//   row_addr/row_go/row_rdy  upstream row request (accepted when row_go & row_rdy)
//   shift_plane/shift_go     one-hot plane to shift, 1-cycle request
//   shift_rdy                shifter idle / done
//   blank_plane/blank_go     one-hot plane display length, 1-cycle start
//   blank_rdy                blanking idle (previous plane expired)
//   hub75_addr, hub75_le     panel row address and latch enable
//
// State table
//   S_IDLE       | waiting for row_go, row_rdy high
//   S_SHIFT      | waiting for shifter idle, then issue shift_go
//   S_SHIFT_HOLD | shift_go cycle; shift_rdy not yet valid
//   S_SHIFT_WAIT | waiting for shifter to finish
//   S_BLANK_WAIT | waiting for previous plane's display time to expire
//   S_LATCH      | hub75_le high for LATCH_LEN cycles
//   S_DISPLAY    | blank_go cycle; choose next plane or return to idle
module hub75_bcm_seq #(
  parameter int N_PLANES   = 8,
  parameter int LOG_N_ROWS = 5,
  parameter int LATCH_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LOG_N_ROWS-1:0] row_addr,
  input  logic                  row_go,
  output logic                  row_rdy,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [N_PLANES-1:0]   blank_plane,
  output logic                  blank_go,
  input  logic                  blank_rdy,
  output logic [LOG_N_ROWS-1:0] hub75_addr,
  output logic                  hub75_le
);

  localparam int PW = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam logic [PW-1:0]       LAST_P     = PW'(N_PLANES - 1);
  localparam logic [3:0]          LATCH_LOAD = 4'(LATCH_LEN - 1);
  localparam logic [N_PLANES-1:0] ONE        = N_PLANES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SHIFT_HOLD,
    S_SHIFT_WAIT,
    S_BLANK_WAIT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         plane_q, plane_d;
  logic                  first_q, first_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  row_rdy_q, row_rdy_d;
  logic                  shift_go_q, shift_go_d;
  logic [N_PLANES-1:0]   shift_plane_q, shift_plane_d;
  logic                  blank_go_q, blank_go_d;
  logic [N_PLANES-1:0]   blank_plane_q, blank_plane_d;
  logic [LOG_N_ROWS-1:0] addr_q, addr_d;
  logic                  le_q, le_d;

  always_comb begin
    state_d       = state_q;
    plane_d       = plane_q;
    first_d       = first_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    row_rdy_d     = row_rdy_q;
    shift_go_d    = 1'b0;
    shift_plane_d = '0;
    blank_go_d    = 1'b0;
    blank_plane_d = '0;
    addr_d        = addr_q;
    le_d          = le_q;

    case (state_q)
      S_IDLE: begin
        row_rdy_d = 1'b1;
        if (row_go) begin
          row_d     = row_addr;
          first_d   = 1'b1;
          plane_d   = LAST_P;
          row_rdy_d = 1'b0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_rdy) begin
          shift_go_d    = 1'b1;
          shift_plane_d = ONE << plane_q;
          state_d       = S_SHIFT_HOLD;
        end
      end
      // shift_rdy still shows the pre-request value here
      S_SHIFT_HOLD: state_d = S_SHIFT_WAIT;
      S_SHIFT_WAIT: begin
        if (shift_rdy) state_d = S_BLANK_WAIT;
      end
      S_BLANK_WAIT: begin
        // panel is blanked once blank_rdy is high, so the address may move now
        if (blank_rdy) begin
          le_d    = 1'b1;
          cnt_d   = LATCH_LOAD;
          state_d = S_LATCH;
          if (first_q) addr_d = row_q;
        end
      end
      S_LATCH: begin
        if (cnt_q == 4'd0) begin
          le_d          = 1'b0;
          blank_go_d    = 1'b1;
          blank_plane_d = ONE << plane_q;
          state_d       = S_DISPLAY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DISPLAY: begin
        first_d = 1'b0;
        if (plane_q == '0) begin
          row_rdy_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          plane_d = plane_q - PW'(1);
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      plane_q       <= LAST_P;
      first_q       <= 1'b0;
      row_q         <= '0;
      cnt_q         <= 4'd0;
      row_rdy_q     <= 1'b1;
      shift_go_q    <= 1'b0;
      shift_plane_q <= '0;
      blank_go_q    <= 1'b0;
      blank_plane_q <= '0;
      addr_q        <= '0;
      le_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      plane_q       <= plane_d;
      first_q       <= first_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      row_rdy_q     <= row_rdy_d;
      shift_go_q    <= shift_go_d;
      shift_plane_q <= shift_plane_d;
      blank_go_q    <= blank_go_d;
      blank_plane_q <= blank_plane_d;
      addr_q        <= addr_d;
      le_q          <= le_d;
    end
  end

  assign row_rdy     = row_rdy_q;
  assign shift_go    = shift_go_q;
  assign shift_plane = shift_plane_q;
  assign blank_go    = blank_go_q;
  assign blank_plane = blank_plane_q;
  assign hub75_addr  = addr_q;
  assign hub75_le    = le_q;

endmodule
